// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle shift/rotate controller. It accepts one operand at a time, keeps
// it in a working register and applies a narrow left shift of at most three
// positions per clock until the requested amount (0..WIDTH-1) is used up.
// The vacated low bits are zero-filled in shift mode. In rotate mode they are
// filled with the bits that leave the MSB end.
//
// Ports:
//   clk         in   clock, all state changes on the rising edge
//   rst         in   synchronous active-high reset
//   req_valid   in   request present
//   req_ready   out  controller can accept a request (IDLE and not in reset)
//   req_data    in   WIDTH-bit operand
//   req_amt     in   AMTW-bit shift/rotate amount
//   req_rot     in   1 = rotate left, 0 = logical shift left
//   resp_valid  out  result available (DONE state)
//   resp_ready  in   consumer takes the result
//   resp_data   out  WIDTH-bit result, stable while resp_valid is high
//   busy        out  high while an operation is running or awaiting pickup
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMTW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [AMTW-1:0]  req_amt,
    input  logic             req_rot,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [AMTW-1:0] MAX_STEP = AMTW'(3);

    state_t            state_q;
    logic [WIDTH-1:0]  work_q;
    logic [AMTW-1:0]   rem_q;
    logic              mode_q;
    logic              resp_valid_q;
    logic              busy_q;
    logic [WIDTH-1:0]  resp_data_q;

    logic [AMTW-1:0]   step;
    logic [AMTW-1:0]   rem_d;
    logic [WIDTH-1:0]  spill;
    logic [WIDTH-1:0]  work_d;

    // One narrow shifter step.
    // The step is the remaining amount clamped to three.
    // spill holds the bits pushed out of the MSB end. A step of zero shifts
    // spill right by WIDTH, which leaves it empty, so no special case is
    // needed for that step.
    always_comb begin
        step   = (rem_q > MAX_STEP) ? MAX_STEP : rem_q;
        rem_d  = rem_q - step;
        spill  = work_q >> (WIDTH - int'(step));
        work_d = (work_q << step) | (mode_q ? spill : '0);
    end

    // Controller FSM.
    // resp_data is captured at the moment the result becomes final. It
    // therefore cannot move while the consumer stalls. Reset wins over any
    // handshake and discards a partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            work_q       <= '0;
            rem_q        <= '0;
            mode_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        work_q <= req_data;
                        rem_q  <= req_amt;
                        mode_q <= req_rot;
                        busy_q <= 1'b1;
                        if (req_amt == '0) begin
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= req_data;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    work_q <= work_d;
                    rem_q  <= rem_d;
                    if (rem_d == '0) begin
                        state_q      <= DONE;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= work_d;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    // req_ready is derived only from the state and rst. This lets a
    // requester see the controller refuse work during the reset cycle.
    assign req_ready  = (state_q == IDLE) && !rst;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
//
// Directed testbench for shift_sequencer.
// Each scenario task drives its own stimulus and checks the outputs against
// hand-computed values. Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_data;
    logic [3:0]  req_amt;
    logic        req_rot;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic        busy;

    int total;
    int bad;

    shift_sequencer #(.WIDTH(16), .AMTW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_amt    (req_amt),
        .req_rot    (req_rot),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a task hangs despite its own bounds.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: sim time expired, required finish");
        $fatal(1, "[TB] watchdog");
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until the edge that accepts it.
    // On return, the time is just after the accepting edge and req_valid is low.
    task automatic send_req(input logic [15:0] d, input logic [3:0] a,
                            input logic r, output logic accepted);
        accepted  = 1'b0;
        req_valid = 1'b1;
        req_data  = d;
        req_amt   = a;
        req_rot   = r;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (req_ready) accepted = 1'b1;
            tick();
        end
        req_valid = 1'b0;
    endtask

    // Count the edges after acceptance until resp_valid appears.
    // The result is -1 if resp_valid does not appear within the limit.
    task automatic wait_resp(input int limit, output int cycles);
        cycles = -1;
        for (int i = 0; i <= limit; i++) begin
            if (resp_valid) begin
                cycles = i;
                break;
            end
            tick();
        end
    endtask

    // Complete a response handshake in one cycle.
    task automatic take_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_req_ready: got %b want 0", req_ready);
        end
        total++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: resp_valid=%b busy=%b want 0/0", resp_valid, busy);
        end
        total++;
        if (resp_data !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset_resp_data: got %h want 0000", resp_data);
        end
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL idle_req_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_shift7();
        logic acc;
        int   cyc;
        send_req(16'h0001, 4'd7, 1'b0, acc);
        req_data = 16'hDEAD;
        req_amt  = 4'd1;
        req_rot  = 1'b1;
        total++;
        if (acc !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL shift7_accept: acc=%b busy=%b want 1/1", acc, busy);
        end
        wait_resp(10, cyc);
        total++;
        if (cyc != 3) begin
            bad++;
            $display("[TB] FAIL shift7_latency: got %0d want 3", cyc);
        end
        total++;
        if (resp_data !== 16'h0080) begin
            bad++;
            $display("[TB] FAIL shift7_data: got %h want 0080", resp_data);
        end
        take_resp();
        total++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL shift7_release: rv=%b busy=%b rr=%b want 0/0/1", resp_valid, busy, req_ready);
        end
    endtask

    task automatic test_amt15();
        logic acc;
        int   cyc;
        send_req(16'hF00F, 4'd15, 1'b1, acc);
        wait_resp(10, cyc);
        total++;
        if (acc !== 1'b1 || cyc != 5) begin
            bad++;
            $display("[TB] FAIL rot15_latency: acc=%b cycles=%0d want 1/5", acc, cyc);
        end
        total++;
        if (resp_data !== 16'hF807) begin
            bad++;
            $display("[TB] FAIL rot15_data: got %h want F807", resp_data);
        end
        take_resp();
        tick();
        send_req(16'hFFFF, 4'd15, 1'b0, acc);
        wait_resp(10, cyc);
        total++;
        if (acc !== 1'b1 || cyc != 5) begin
            bad++;
            $display("[TB] FAIL shl15_latency: acc=%b cycles=%0d want 1/5", acc, cyc);
        end
        total++;
        if (resp_data !== 16'h8000) begin
            bad++;
            $display("[TB] FAIL shl15_data: got %h want 8000", resp_data);
        end
        take_resp();
        tick();
    endtask

    task automatic test_amt0();
        logic acc;
        int   cyc;
        for (int m = 0; m < 2; m++) begin
            send_req(16'hA5A5, 4'd0, m[0], acc);
            wait_resp(0, cyc);
            total++;
            if (acc !== 1'b1 || cyc != 0) begin
                bad++;
                $display("[TB] FAIL amt0_latency mode=%0d: acc=%b cycles=%0d want 1/0", m, acc, cyc);
            end
            total++;
            if (resp_data !== 16'hA5A5 || busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL amt0_data mode=%0d: data=%h busy=%b want A5A5/1", m, resp_data, busy);
            end
            take_resp();
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL amt0_busy_drop mode=%0d: got %b want 0", m, busy);
            end
            tick();
        end
    endtask

    task automatic test_hold();
        logic acc;
        int   cyc;
        int   errs;
        errs = 0;
        send_req(16'h8001, 4'd1, 1'b1, acc);
        wait_resp(5, cyc);
        total++;
        if (acc !== 1'b1 || cyc != 1) begin
            bad++;
            $display("[TB] FAIL hold_latency: acc=%b cycles=%0d want 1/1", acc, cyc);
        end
        for (int i = 0; i < 4; i++) begin
            if (resp_valid !== 1'b1 || resp_data !== 16'h0003 || req_ready !== 1'b0) begin
                errs++;
                $display("[TB] FAIL hold_stable c%0d: rv=%b data=%h rr=%b want 1/0003/0", i, resp_valid, resp_data, req_ready);
            end
            tick();
        end
        total++;
        if (errs != 0) bad++;
        take_resp();
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL hold_release: rv=%b rr=%b want 0/1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset_midrun();
        logic acc;
        int   cyc;
        int   seen;
        seen = 0;
        send_req(16'h0001, 4'd9, 1'b0, acc);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_data !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL midrun_reset: rv=%b busy=%b data=%h want 0/0/0000", resp_valid, busy, resp_data);
        end
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midrun_idle: req_ready=%b want 1", req_ready);
        end
        for (int i = 0; i < 8; i++) begin
            if (resp_valid) seen++;
            tick();
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("[TB] FAIL midrun_no_resp: valid cycles=%0d want 0", seen);
        end
        send_req(16'h0003, 4'd2, 1'b0, acc);
        wait_resp(5, cyc);
        total++;
        if (acc !== 1'b1 || cyc != 1 || resp_data !== 16'h000C) begin
            bad++;
            $display("[TB] FAIL midrun_next: acc=%b cycles=%0d data=%h want 1/1/000C", acc, cyc, resp_data);
        end
        take_resp();
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int errs;
        errs = 0;
        req_valid = 1'b1;
        req_data  = 16'h0011;
        req_amt   = 4'd5;
        req_rot   = 1'b0;
        tick();
        // Second request is presented immediately and stays valid.
        req_data = 16'h8421;
        req_amt  = 4'd3;
        req_rot  = 1'b1;
        for (int i = 0; i < 6 && !resp_valid; i++) begin
            if (req_ready !== 1'b0) errs++;
            tick();
        end
        total++;
        if (errs != 0 || resp_valid !== 1'b1 || req_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_blocked: errs=%0d rv=%b rr=%b want 0/1/0", errs, resp_valid, req_ready);
        end
        total++;
        if (resp_data !== 16'h0220) begin
            bad++;
            $display("[TB] FAIL b2b_first_data: got %h want 0220", resp_data);
        end
        take_resp();
        total++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_idle_gap: busy=%b rr=%b want 0/1", busy, req_ready);
        end
        tick();
        req_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_second_accept: busy=%b want 1", busy);
        end
        wait_resp(5, cyc);
        total++;
        if (cyc != 1 || resp_data !== 16'h210C) begin
            bad++;
            $display("[TB] FAIL b2b_second_data: cycles=%0d data=%h want 1/210C", cyc, resp_data);
        end
        take_resp();
        tick();
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_data   = '0;
        req_amt    = '0;
        req_rot    = 1'b0;
        resp_ready = 1'b0;
        test_reset();
        test_shift7();
        test_amt15();
        test_amt0();
        test_hold();
        test_reset_midrun();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
